// File: rtl/mem_stage_if.sv
// Valid/allowin/bus handshake between two adjacent pipeline stages.
interface mem_stage_if #(
  parameter int unsigned BUS_W = 32
);
  logic             valid;
  logic             allowin;
  logic [BUS_W-1:0] bus;

  // Upstream stage drives valid and payload
  modport master (output valid, output bus, input allowin);
  // Downstream stage answers with allowin
  modport slave (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage.sv
// MEM stage: holds the EX bundle, collects the data-SRAM response, extracts
// load data and drops responses owned by flushed instructions.
module mem_stage #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  es2ms,
  mem_stage_if.master ms2ws,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [38:0] ms_rf_zip,
  output logic        ms_ld_blk,
  output logic        ms_ex,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        wb_refetch_flush
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [4:0]  ld_op;        // one-hot {b, h, w, bu, hu}
    logic        mem_req;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        csr_re;
    logic [78:0] csr_zip;
    logic [6:0]  except_zip;
    logic [9:0]  tlb_zip;
  } es_bus_t;

  es_bus_t          es_in;
  es_bus_t          ms_bus_q, ms_bus_d;
  logic             ms_valid_q, ms_valid_d;
  logic             buf_valid_q, buf_valid_d;
  logic [31:0]      buf_data_q, buf_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             flush;
  logic             cnt_busy;
  logic             cnt_eat;
  logic             beat_live;
  logic             owner;
  logic             data_ready;
  logic             ms_ready_go;
  logic             ms_leave;
  logic             ms_allowin;
  logic [SUM_W-1:0] cnt_sum;
  logic [31:0]      ld_src;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_result;
  logic [31:0]      final_wdata;

  assign es_in = es_bus_t'(es2ms.bus);

  // Response ownership, handshake and next-state for all stage registers
  always_comb begin
    flush       = wb_ex | ertn_flush | wb_refetch_flush;
    cnt_busy    = (cnt_q != '0);
    cnt_eat     = data_sram_data_ok & cnt_busy;
    beat_live   = data_sram_data_ok & ~cnt_busy;
    owner       = ms_valid_q & ms_bus_q.mem_req & ~buf_valid_q;
    data_ready  = ~ms_bus_q.mem_req | buf_valid_q | beat_live;
    ms_ready_go = data_ready;
    ms_leave    = ms_ready_go & ms2ws.allowin;
    ms_allowin  = ~ms_valid_q | ms_leave;

    ms_valid_d  = ms_valid_q;
    ms_bus_d    = ms_bus_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;

    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms.valid;
    end

    if (es2ms.valid & ms_allowin & ~flush) begin
      ms_bus_d = es_in;
    end

    if (flush | ms_leave) begin
      buf_valid_d = 1'b0;
    end else if (owner & beat_live) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end

    // A flush orphans the unanswered request in MEM and any request EX issued
    cnt_sum = SUM_W'(cnt_q) - SUM_W'(cnt_eat);
    if (flush) begin
      cnt_sum = cnt_sum + SUM_W'(owner & ~beat_live)
                        + SUM_W'(es2ms.valid & es_in.mem_req);
    end
    cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum);
  end

  // Load data extraction and writeback value
  always_comb begin
    ld_src  = buf_valid_q ? buf_data_q : data_sram_rdata;
    ld_byte = 8'(ld_src >> {ms_bus_q.alu_result[1:0], 3'b000});
    ld_half = ms_bus_q.alu_result[1] ? ld_src[31:16] : ld_src[15:0];
    load_result = ld_src;
    if (ms_bus_q.ld_op[4]) begin
      load_result = {{24{ld_byte[7]}}, ld_byte};
    end else if (ms_bus_q.ld_op[3]) begin
      load_result = {{16{ld_half[15]}}, ld_half};
    end else if (ms_bus_q.ld_op[1]) begin
      load_result = {24'd0, ld_byte};
    end else if (ms_bus_q.ld_op[0]) begin
      load_result = {16'd0, ld_half};
    end
    final_wdata = ms_bus_q.res_from_mem ? load_result : ms_bus_q.alu_result;
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      ms_bus_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      ms_bus_q    <= ms_bus_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign es2ms.allowin = ms_allowin;
  assign ms2ws.valid   = ms_valid_q & ms_ready_go & ~flush;
  assign ms2ws.bus     = {ms_bus_q.alu_result, ms_bus_q.pc, ms_bus_q.csr_zip,
                          ms_bus_q.except_zip, ms_bus_q.tlb_zip};
  assign ms_rf_zip     = {ms_bus_q.csr_re, ms_bus_q.rf_we & ms_valid_q,
                          ms_bus_q.rf_waddr, final_wdata};
  assign ms_ld_blk     = ms_valid_q & ms_bus_q.res_from_mem & ~data_ready;
  assign ms_ex         = ms_valid_q & (|ms_bus_q.except_zip);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load latency, extension, back-pressure,
// flush discard counting, non-memory ops and reset.
module tb_mem_stage;

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_H  = 5'b01000;
  localparam logic [4:0] OP_W  = 5'b00100;
  localparam logic [4:0] OP_BU = 5'b00010;
  localparam logic [4:0] OP_HU = 5'b00001;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_ok;
  logic [31:0] rdata;
  logic        wb_ex, ertn_flush, wb_refetch_flush;
  logic [38:0] ms_rf_zip;
  logic        ms_ld_blk, ms_ex;
  int          checks = 0;
  int          errors = 0;

  mem_stage_if #(.BUS_W(174)) es2ms_if ();
  mem_stage_if #(.BUS_W(160)) ms2ws_if ();

  mem_stage #(.CNT_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .es2ms             (es2ms_if),
    .ms2ws             (ms2ws_if),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_rf_zip         (ms_rf_zip),
    .ms_ld_blk         (ms_ld_blk),
    .ms_ex             (ms_ex),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .wb_refetch_flush  (wb_refetch_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [173:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                      input logic [4:0] op, input logic mem_req,
                                      input logic res_mem, input logic rf_we,
                                      input logic [4:0] waddr, input logic csr_re,
                                      input logic [78:0] csr_zip, input logic [6:0] exc,
                                      input logic [9:0] tlb);
    return {pc, alu, op, mem_req, res_mem, rf_we, waddr, csr_re, csr_zip, exc, tlb};
  endfunction

  function automatic logic [173:0] mk_ld(input logic [31:0] addr, input logic [4:0] op,
                                         input logic [4:0] waddr);
    return mk(32'h1c00_0000, addr, op, 1'b1, 1'b1, 1'b1, waddr, 1'b0, '0, '0, '0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [173:0] b);
    es2ms_if.valid = 1'b1;
    es2ms_if.bus   = b;
    tick();
    es2ms_if.valid = 1'b0;
    es2ms_if.bus   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    es2ms_if.valid = 1'b0; es2ms_if.bus = '0; ms2ws_if.allowin = 1'b1;
    data_ok = 1'b0; rdata = '0; wb_ex = 1'b0; ertn_flush = 1'b0; wb_refetch_flush = 1'b0;
    tick(); tick();
    checks++; if (es2ms_if.allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b exp 1", es2ms_if.allowin); end
    checks++; if (ms2ws_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ms2ws_if.valid); end
    checks++; if (ms_ld_blk !== 1'b0) begin errors++; $display("FAIL reset_ld_blk got %b exp 0", ms_ld_blk); end
    checks++; if (ms_ex !== 1'b0) begin errors++; $display("FAIL reset_ms_ex got %b exp 0", ms_ex); end
    checks++; if (ms_rf_zip[37] !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", ms_rf_zip[37]); end
    checks++; if (ms2ws_if.bus !== 160'd0) begin errors++; $display("FAIL reset_bus got %h exp 0", ms2ws_if.bus); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stray_beat();
    data_ok = 1'b1; rdata = 32'hAAAA_5555;
    tick();
    data_ok = 1'b0;
    send(mk_ld(32'h0000_0100, OP_W, 5'd1));
    checks++; if (ms_ld_blk !== 1'b1) begin errors++; $display("FAIL stray_ld_blk got %b exp 1", ms_ld_blk); end
    data_ok = 1'b1; rdata = 32'h0102_0304; #1;
    checks++; if (ms_rf_zip[31:0] !== 32'h0102_0304) begin errors++; $display("FAIL stray_wdata got %h exp 01020304", ms_rf_zip[31:0]); end
    tick();
    data_ok = 1'b0;
  endtask

  task automatic test_load_word();
    send(mk_ld(32'h0000_1000, OP_W, 5'd5));
    for (int i = 1; i <= 3; i++) begin
      checks++; if (ms_ld_blk !== 1'b1) begin errors++; $display("FAIL lw_blk_c%0d got %b exp 1", i, ms_ld_blk); end
      checks++; if (ms2ws_if.valid !== 1'b0) begin errors++; $display("FAIL lw_wait_valid_c%0d got %b exp 0", i, ms2ws_if.valid); end
      tick();
    end
    data_ok = 1'b1; rdata = 32'h8899_AABB; #1;
    checks++; if (ms2ws_if.valid !== 1'b1) begin errors++; $display("FAIL lw_valid got %b exp 1", ms2ws_if.valid); end
    checks++; if (ms_ld_blk !== 1'b0) begin errors++; $display("FAIL lw_blk_done got %b exp 0", ms_ld_blk); end
    checks++; if (ms_rf_zip[37:0] !== {1'b1, 5'd5, 32'h8899_AABB}) begin errors++; $display("FAIL lw_rf got %h exp %h", ms_rf_zip[37:0], {1'b1, 5'd5, 32'h8899_AABB}); end
    tick();
    data_ok = 1'b0; #1;
    checks++; if (ms2ws_if.valid !== 1'b0) begin errors++; $display("FAIL lw_pulse got %b exp 0", ms2ws_if.valid); end
    checks++; if (es2ms_if.allowin !== 1'b1) begin errors++; $display("FAIL lw_allowin got %b exp 1", es2ms_if.allowin); end
  endtask

  task automatic test_load_ext();
    logic [4:0]  ops  [5] = '{OP_B, OP_BU, OP_H, OP_HU, OP_B};
    logic [31:0] addrs[5] = '{32'h0000_2003, 32'h0000_2003, 32'h0000_2002, 32'h0000_2000, 32'h0000_2001};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_2233, 32'h0000_0022};
    for (int i = 0; i < 5; i++) begin
      send(mk_ld(addrs[i], ops[i], 5'd2));
      data_ok = 1'b1; rdata = 32'h8011_2233; #1;
      checks++; if (ms2ws_if.valid !== 1'b1 || ms_rf_zip[31:0] !== exps[i]) begin
        errors++; $display("FAIL ext_%0d got v=%b %h exp v=1 %h", i, ms2ws_if.valid, ms_rf_zip[31:0], exps[i]);
      end
      tick();
      data_ok = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    send(mk_ld(32'h0000_2000, OP_W, 5'd6));
    ms2ws_if.allowin = 1'b0;
    es2ms_if.valid = 1'b1; es2ms_if.bus = mk_ld(32'h0000_2004, OP_W, 5'd7);
    data_ok = 1'b1; rdata = 32'hCAFE_F00D; #1;
    checks++; if (es2ms_if.allowin !== 1'b0) begin errors++; $display("FAIL bp_allowin got %b exp 0", es2ms_if.allowin); end
    for (int i = 0; i < 4; i++) begin
      tick();
      data_ok = 1'b0; rdata = 32'hDEAD_BEEF; #1;
      checks++; if (ms2ws_if.valid !== 1'b1 || ms_rf_zip[31:0] !== 32'hCAFE_F00D) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b %h exp v=1 cafef00d", i, ms2ws_if.valid, ms_rf_zip[31:0]);
      end
      checks++; if (ms2ws_if.bus[159:128] !== 32'h0000_2000 || es2ms_if.allowin !== 1'b0) begin
        errors++; $display("FAIL bp_stable_%0d got %h/%b exp 00002000/0", i, ms2ws_if.bus[159:128], es2ms_if.allowin);
      end
    end
    ms2ws_if.allowin = 1'b1; #1;
    checks++; if (es2ms_if.allowin !== 1'b1 || ms_rf_zip[31:0] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL bp_release got %b %h exp 1 cafef00d", es2ms_if.allowin, ms_rf_zip[31:0]);
    end
    tick();
    es2ms_if.valid = 1'b0; es2ms_if.bus = '0; #1;
    checks++; if (ms_ld_blk !== 1'b1 || ms2ws_if.valid !== 1'b0) begin
      errors++; $display("FAIL bp_next_wait got blk=%b v=%b exp 1 0", ms_ld_blk, ms2ws_if.valid);
    end
    data_ok = 1'b1; rdata = 32'h0BAD_CAFE; #1;
    checks++; if (ms_rf_zip[36:0] !== {5'd7, 32'h0BAD_CAFE}) begin
      errors++; $display("FAIL bp_next_data got %h exp %h", ms_rf_zip[36:0], {5'd7, 32'h0BAD_CAFE});
    end
    tick();
    data_ok = 1'b0;
  endtask

  task automatic test_discard();
    send(mk_ld(32'h0000_3000, OP_W, 5'd8));
    es2ms_if.valid = 1'b1; es2ms_if.bus = mk_ld(32'h0000_3004, OP_W, 5'd8);
    wb_ex = 1'b1; #1;
    checks++; if (ms2ws_if.valid !== 1'b0) begin errors++; $display("FAIL dis_flush_valid got %b exp 0", ms2ws_if.valid); end
    tick();
    wb_ex = 1'b0; es2ms_if.valid = 1'b0; es2ms_if.bus = '0; #1;
    checks++; if (es2ms_if.allowin !== 1'b1) begin errors++; $display("FAIL dis_allowin got %b exp 1", es2ms_if.allowin); end
    send(mk_ld(32'h0000_4000, OP_W, 5'd9));
    data_ok = 1'b1; rdata = 32'h1111_1111; #1;
    checks++; if (ms2ws_if.valid !== 1'b0 || ms_ld_blk !== 1'b1) begin errors++; $display("FAIL dis_drop1 got v=%b blk=%b exp 0 1", ms2ws_if.valid, ms_ld_blk); end
    tick();
    rdata = 32'h2222_2222; #1;
    checks++; if (ms2ws_if.valid !== 1'b0 || ms_ld_blk !== 1'b1) begin errors++; $display("FAIL dis_drop2 got v=%b blk=%b exp 0 1", ms2ws_if.valid, ms_ld_blk); end
    tick();
    rdata = 32'h3333_3333; #1;
    checks++; if (ms2ws_if.valid !== 1'b1 || ms_rf_zip[31:0] !== 32'h3333_3333) begin
      errors++; $display("FAIL dis_deliver got v=%b %h exp 1 33333333", ms2ws_if.valid, ms_rf_zip[31:0]);
    end
    tick();
    data_ok = 1'b0; #1;
    checks++; if (ms2ws_if.valid !== 1'b0) begin errors++; $display("FAIL dis_after got %b exp 0", ms2ws_if.valid); end
  endtask

  task automatic test_flush_same_cycle();
    send(mk_ld(32'h0000_5000, OP_W, 5'd10));
    wb_refetch_flush = 1'b1; data_ok = 1'b1; rdata = 32'h5555_5555; #1;
    checks++; if (ms2ws_if.valid !== 1'b0) begin errors++; $display("FAIL fsc_valid got %b exp 0", ms2ws_if.valid); end
    tick();
    wb_refetch_flush = 1'b0; data_ok = 1'b0;
    send(mk_ld(32'h0000_5004, OP_W, 5'd11));
    data_ok = 1'b1; rdata = 32'h6666_6666; #1;
    checks++; if (ms2ws_if.valid !== 1'b1 || ms_rf_zip[31:0] !== 32'h6666_6666) begin
      errors++; $display("FAIL fsc_next got v=%b %h exp 1 66666666", ms2ws_if.valid, ms_rf_zip[31:0]);
    end
    tick();
    data_ok = 1'b0;
  endtask

  task automatic test_non_mem();
    logic [78:0] csr = 79'h0ABCD_1234_5678_9ABC_DEF0;
    send(mk(32'h1c00_0040, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, csr, 7'h00, 10'h2A5));
    checks++; if (ms2ws_if.valid !== 1'b1 || ms_ld_blk !== 1'b0 || ms_ex !== 1'b0) begin
      errors++; $display("FAIL alu_ctrl got v=%b blk=%b ex=%b exp 1 0 0", ms2ws_if.valid, ms_ld_blk, ms_ex);
    end
    checks++; if (ms_rf_zip !== {1'b1, 1'b1, 5'd3, 32'h0000_1234}) begin
      errors++; $display("FAIL alu_rf got %h exp %h", ms_rf_zip, {1'b1, 1'b1, 5'd3, 32'h0000_1234});
    end
    checks++; if (ms2ws_if.bus !== {32'h0000_1234, 32'h1c00_0040, csr, 7'h00, 10'h2A5}) begin
      errors++; $display("FAIL alu_bus got %h exp %h", ms2ws_if.bus, {32'h0000_1234, 32'h1c00_0040, csr, 7'h00, 10'h2A5});
    end
    send(mk(32'h1c00_0044, 32'h0000_0042, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, '0, 7'h04, 10'h000));
    checks++; if (ms_ex !== 1'b1 || ms2ws_if.valid !== 1'b1) begin
      errors++; $display("FAIL exc_ms_ex got ex=%b v=%b exp 1 1", ms_ex, ms2ws_if.valid);
    end
    ertn_flush = 1'b1; #1;
    checks++; if (ms2ws_if.valid !== 1'b0) begin errors++; $display("FAIL ertn_valid got %b exp 0", ms2ws_if.valid); end
    tick();
    ertn_flush = 1'b0; #1;
    checks++; if (ms_ex !== 1'b0 || ms_rf_zip[37] !== 1'b0) begin
      errors++; $display("FAIL ertn_clear got ex=%b we=%b exp 0 0", ms_ex, ms_rf_zip[37]);
    end
  endtask

  task automatic test_reset_mid();
    send(mk_ld(32'h0000_6000, OP_W, 5'd12));
    wb_ex = 1'b1;
    tick();
    wb_ex = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    checks++; if (es2ms_if.allowin !== 1'b1 || ms2ws_if.valid !== 1'b0 || ms_ld_blk !== 1'b0) begin
      errors++; $display("FAIL rst_mid got a=%b v=%b blk=%b exp 1 0 0", es2ms_if.allowin, ms2ws_if.valid, ms_ld_blk);
    end
    send(mk_ld(32'h0000_6004, OP_W, 5'd13));
    data_ok = 1'b1; rdata = 32'h7777_7777; #1;
    checks++; if (ms2ws_if.valid !== 1'b1 || ms_rf_zip[31:0] !== 32'h7777_7777) begin
      errors++; $display("FAIL rst_mid_deliver got v=%b %h exp 1 77777777", ms2ws_if.valid, ms_rf_zip[31:0]);
    end
    tick();
    data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stray_beat();
    test_load_word();
    test_load_ext();
    test_backpressure();
    test_discard();
    test_flush_same_cycle();
    test_non_mem();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
